// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between NREQ requesters with round-robin grant, one op in flight.
// Latency: accept at cycle T, alu_en at T+1, rsp_valid at T+2; back-to-back accepts 3 cycles apart.
// Backpressure: response held in RESP until the owner's rsp_ready; req_ready stays 0 until back in IDLE.
// Ports: clk/rst_n; req_valid/req_ready/req_op1/req_op2/req_mode per requester (flattened);
//        rsp_valid/rsp_ready per requester, shared rsp_data/rsp_flags {Z,C,S,O};
//        alu_op1/alu_op2/alu_mode/alu_en/alu_cflags to the ALU, alu_out/alu_flags back;
//        status = per-requester {Z,C,S,O} registers, requester i at [4i+3:4i].
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_op1,
  input  logic [NREQ*8-1:0] req_op2,
  input  logic [NREQ*4-1:0] req_mode,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [7:0]        rsp_data,
  output logic [3:0]        rsp_flags,
  output logic [7:0]        alu_op1,
  output logic [7:0]        alu_op2,
  output logic [3:0]        alu_mode,
  output logic              alu_en,
  output logic [3:0]        alu_cflags,
  input  logic [7:0]        alu_out,
  input  logic [3:0]        alu_flags,
  output logic [NREQ*4-1:0] status
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] ptr_next;
  logic           grant_vld;
  logic [7:0]     op1_q;
  logic [7:0]     op2_q;
  logic [3:0]     mode_q;
  logic [3:0]     stat [NREQ];
  int             arb_idx;

  // Round-robin search. Offsets are walked from the farthest down to ptr itself,
  // so the last hit written is the first valid requester at or after ptr.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    arb_idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      arb_idx = int'(ptr) + k;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      if (req_valid[arb_idx]) begin
        grant     = IDW'(arb_idx);
        grant_vld = 1'b1;
      end
    end
  end

  assign ptr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_vld) req_ready[grant] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP) rsp_valid[owner] = 1'b1;
  end

  // ALU operand ports hold the last accepted op; only alu_en marks the live cycle.
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_mode   = mode_q;
  assign alu_en     = (state == S_EXEC);
  assign alu_cflags = stat[owner];

  for (genvar i = 0; i < NREQ; i++) begin : g_status
    assign status[4*i+3:4*i] = stat[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      owner     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      mode_q    <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      for (int i = 0; i < NREQ; i++) stat[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            op1_q  <= req_op1[8*grant +: 8];
            op2_q  <= req_op2[8*grant +: 8];
            mode_q <= req_mode[4*grant +: 4];
            owner  <= grant;
            ptr    <= ptr_next;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data    <= alu_out;
          rsp_flags   <= alu_flags;
          stat[owner] <= alu_flags;
          state       <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's consume bit matters; other rsp_ready bits are ignored.
          if (rsp_ready[owner]) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: exercises alu_arbiter with NREQ=3 against a behavioural ALU model and a scoreboard.
// Latency: checks accept at T, alu_en at T+1, rsp_valid at T+2.
// Backpressure: holds rsp_ready low on the owner and confirms response and req_ready stay put.
module tb_alu_arbiter;
  localparam int NREQ = 3;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_op1;
  logic [NREQ*8-1:0] req_op2;
  logic [NREQ*4-1:0] req_mode;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [7:0]        rsp_data;
  logic [3:0]        rsp_flags;
  logic [7:0]        alu_op1;
  logic [7:0]        alu_op2;
  logic [3:0]        alu_mode;
  logic              alu_en;
  logic [3:0]        alu_cflags;
  logic [7:0]        alu_out;
  logic [3:0]        alu_flags;
  logic [NREQ*4-1:0] status;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_mode(alu_mode),
    .alu_en(alu_en), .alu_cflags(alu_cflags),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .status(status)
  );

  always #5 clk = ~clk;

  // ALU modes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADC (carry from cflags C). Result {Z,C,S,O,data}.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] m, input logic [3:0] cf);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    logic       o;
    s = '0; r = '0; c = 1'b0; o = 1'b0;
    case (m)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; o = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin s = {1'b0, a} + {1'b0, b} + {8'b0, cf[2]}; r = s[7:0]; c = s[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
      default: r = a;
    endcase
    return {(r == 8'h00), c, r[7], o, r};
  endfunction

  always_comb begin
    {alu_flags, alu_out} = alu_ref(alu_op1, alu_op2, alu_mode, alu_cflags);
  end

  typedef struct packed {
    logic [1:0] own;
    logic [3:0] f;
    logic [7:0] d;
  } exp_t;

  exp_t       sb [$];
  logic [3:0] st_m [NREQ];
  int         checks = 0;
  int         errors = 0;

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
    req_op1[8*r +: 8]  = a;
    req_op2[8*r +: 8]  = b;
    req_mode[4*r +: 4] = m;
  endtask

  // Expected result of requester r's currently presented op; model status follows the accept.
  task automatic push_exp(input int r);
    logic [11:0] res;
    exp_t        e;
    res   = alu_ref(req_op1[8*r +: 8], req_op2[8*r +: 8], req_mode[4*r +: 4], st_m[r]);
    e.own = 2'(r);
    e.f   = res[11:8];
    e.d   = res[7:0];
    sb.push_back(e);
    st_m[r] = res[11:8];
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_op1   = '0;
    req_op2   = '0;
    req_mode  = '0;
    sb.delete();
    for (int i = 0; i < NREQ; i++) st_m[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one op for requester r alone and captures what the DUT shows; no judgement here.
  task automatic run_op(input int r, input logic [7:0] a, input logic [7:0] b, input logic [3:0] m,
                        output logic ok, output logic [3:0] cf, output logic [NREQ-1:0] vld,
                        output logic [7:0] d, output logic [3:0] f);
    int n;
    @(negedge clk);
    set_req(r, a, b, m);
    req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[r] && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = req_ready[r];
    if (ok) push_exp(r);
    @(negedge clk);
    req_valid[r] = 1'b0;
    cf = alu_cflags;
    @(negedge clk);
    vld = rsp_valid;
    d   = rsp_data;
    f   = rsp_flags;
    rsp_ready[r] = 1'b1;
    @(negedge clk);
    rsp_ready[r] = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_flags, alu_op1, alu_op2, alu_mode, alu_en, alu_cflags, status} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h flags=%h op1=%h op2=%h mode=%h en=%b cf=%h status=%h, want all 0",
               req_ready, rsp_valid, rsp_data, rsp_flags, alu_op1, alu_op2, alu_mode, alu_en, alu_cflags, status);
    end
  endtask

  task automatic test_single_op();
    exp_t e;
    reset_dut();
    set_req(0, 8'hF0, 8'h20, 4'd0);
    req_valid = 3'b001;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL single_accept: req_ready=%b want 001", req_ready); end
    push_exp(0);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if ({alu_en, alu_op1, alu_op2, alu_mode} !== {1'b1, 8'hF0, 8'h20, 4'd0}) begin
      errors++;
      $display("FAIL single_exec: en=%b op1=%h op2=%h mode=%h want 1 f0 20 0", alu_en, alu_op1, alu_op2, alu_mode);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 3'b001) begin errors++; $display("FAIL single_rsp_valid: %b want 001", rsp_valid); end
    checks++;
    if (rsp_data !== 8'h10) begin errors++; $display("FAIL single_data: %h want 10", rsp_data); end
    e = sb.pop_front();
    checks++;
    if (rsp_flags !== e.f) begin errors++; $display("FAIL single_flags: %b want %b", rsp_flags, e.f); end
    checks++;
    if (status[2] !== 1'b1) begin errors++; $display("FAIL single_status_c: status=%h want C of req0 set", status); end
    rsp_ready = 3'b001;
    @(negedge clk);
    rsp_ready = '0;
    checks++;
    if (rsp_valid !== 3'b000) begin errors++; $display("FAIL single_release: rsp_valid=%b want 000", rsp_valid); end
  endtask

  task automatic test_fairness();
    exp_t       e;
    int         own;
    logic [2:0] oh;
    reset_dut();
    set_req(0, 8'h90, 8'h90, 4'd5);
    set_req(1, 8'h05, 8'h07, 4'd1);
    req_valid = 3'b011;
    rsp_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      own = i % 2;
      oh  = 3'b001 << own;
      #1;
      checks++;
      if (req_ready !== oh) begin errors++; $display("FAIL fair_grant%0d: req_ready=%b want %b", i, req_ready, oh); end
      push_exp(own);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== oh) begin errors++; $display("FAIL fair_rsp%0d: rsp_valid=%b want %b", i, rsp_valid, oh); end
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL fair_sb%0d: scoreboard empty, want one entry", i);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({rsp_data, rsp_flags} !== {e.d, e.f}) begin
          errors++;
          $display("FAIL fair_data%0d: data=%h flags=%b want %h %b", i, rsp_data, rsp_flags, e.d, e.f);
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    reset_dut();
    set_req(1, 8'h7F, 8'h01, 4'd0);
    req_valid = 3'b010;
    #1;
    push_exp(1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    req_valid = 3'b001;
    rsp_ready = 3'b101;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_data, rsp_flags, req_ready} !== {3'b010, e.d, e.f, 3'b000}) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b data=%h flags=%b rdy=%b want 010 %h %b 000",
                 i, rsp_valid, rsp_data, rsp_flags, req_ready, e.d, e.f);
      end
      @(negedge clk);
    end
    rsp_ready = 3'b010;
    @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, req_ready} !== {3'b000, 3'b001}) begin
      errors++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b want 000 001", rsp_valid, req_ready);
    end
    req_valid = '0;
    rsp_ready = '0;
  endtask

  task automatic test_status();
    logic            ok;
    logic [3:0]      cf;
    logic [NREQ-1:0] vld;
    logic [7:0]      d;
    logic [3:0]      f;
    exp_t            e;
    reset_dut();
    run_op(1, 8'h55, 8'h55, 4'd4, ok, cf, vld, d, f);
    e = sb.pop_front();
    checks++;
    if ({ok, vld, d, f, cf} !== {1'b1, 3'b010, e.d, e.f, 4'b0000}) begin
      errors++;
      $display("FAIL status_xor: ok=%b vld=%b data=%h flags=%b cf=%b want 1 010 %h %b 0000", ok, vld, d, f, cf, e.d, e.f);
    end
    run_op(0, 8'hFF, 8'h81, 4'd2, ok, cf, vld, d, f);
    e = sb.pop_front();
    checks++;
    if ({ok, vld, d, f} !== {1'b1, 3'b001, e.d, e.f}) begin
      errors++;
      $display("FAIL status_and: ok=%b vld=%b data=%h flags=%b want 1 001 %h %b", ok, vld, d, f, e.d, e.f);
    end
    checks++;
    if ({status[7], status[1]} !== 2'b11) begin
      errors++;
      $display("FAIL status_bits: status=%h want req1 Z and req0 S set", status);
    end
    run_op(1, 8'h01, 8'h01, 4'd5, ok, cf, vld, d, f);
    e = sb.pop_front();
    checks++;
    if ({cf, d} !== {st_m[0] ^ st_m[0] ^ 4'b1000, e.d}) begin
      errors++;
      $display("FAIL status_cflags: cflags=%b data=%h want 1000 %h", cf, d, e.d);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic            ok;
    logic [3:0]      cf;
    logic [NREQ-1:0] vld;
    logic [7:0]      d;
    logic [3:0]      f;
    reset_dut();
    run_op(0, 8'hF0, 8'h20, 4'd0, ok, cf, vld, d, f);
    void'(sb.pop_front());
    @(negedge clk);
    set_req(1, 8'h03, 8'h04, 4'd0);
    req_valid = 3'b010;
    @(negedge clk);
    checks++;
    if (alu_en !== 1'b1) begin errors++; $display("FAIL rst_exec_en: alu_en=%b want 1", alu_en); end
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_flags, alu_op1, alu_op2, alu_mode, alu_en, alu_cflags, status} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: rdy=%b vld=%b data=%h flags=%h op1=%h op2=%h mode=%h en=%b cf=%h status=%h, want all 0",
               req_ready, rsp_valid, rsp_data, rsp_flags, alu_op1, alu_op2, alu_mode, alu_en, alu_cflags, status);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 3'b000) begin errors++; $display("FAIL rst_no_rsp%0d: rsp_valid=%b want 000", i, rsp_valid); end
    end
    req_valid = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL rst_first_grant: req_ready=%b want 001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    logic            ok;
    logic [3:0]      cf;
    logic [NREQ-1:0] vld;
    logic [7:0]      d;
    logic [3:0]      f;
    reset_dut();
    run_op(1, 8'h11, 8'h22, 4'd3, ok, cf, vld, d, f);
    void'(sb.pop_front());
    checks++;
    if ({ok, vld, d} !== {1'b1, 3'b010, 8'h33}) begin
      errors++;
      $display("FAIL wrap_setup: ok=%b vld=%b data=%h want 1 010 33", ok, vld, d);
    end
    req_valid = 3'b001;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL wrap_grant0: req_ready=%b want 001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rsp_ready = 3'b001;
    @(negedge clk);
    rsp_ready = '0;
    req_valid = 3'b011;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL wrap_ptr: req_ready=%b want 010", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fairness();
    test_backpressure();
    test_status();
    test_reset_mid_exec();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
